// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx - device-side (keyboard) PS/2 transmitter.
//
// Scancode bytes written through kbd_data/kbd_stb are queued in a small FIFO
// and serialised onto ps2_clk/ps2_data as 11-bit frames: start (0), eight data
// bits LSB first, odd parity, stop (1). One "tick" is PS2DIV+1 clk_p cycles,
// i.e. half a PS/2 clock period. Data only changes while ps2_clk is high, so
// the receiver can sample on every falling edge. After each frame the lines
// stay high for GAP_TICKS ticks before the next byte is considered.
//
// Optional feature: define PS2_TX_INHIBIT_EN to add the ps2_inhibit input.
// With it, the host can hold off frame starts (IDLE/GAP) and abort a frame
// before the stop bit is clocked; an aborted byte stays queued and is resent.
// Without it, ps2_inhibit does not exist and frames are never aborted.
module ps2_kbd_tx #(
    parameter logic [13:0] PS2DIV    = 14'd3332,
    parameter int          FIFO_AW   = 4,
    parameter int          GAP_TICKS = 4
) (
    input  logic       clk_p,
    input  logic       nreset,
    input  logic [7:0] kbd_data,
    input  logic       kbd_stb,
    output logic       kbd_full,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
`ifdef PS2_TX_INHIBIT_EN
    ,
    input  logic       ps2_inhibit
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_TICKS - 1);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
    localparam logic [3:0]       LAST_BIT   = 4'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic [FIFO_AW:0]   count_next;
    logic               fifo_empty;
    logic               fifo_wr;
    logic               fifo_pop;
    logic [7:0]         head_byte;
    logic               ovf_reg;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [13:0]      div_reg;
    logic [13:0]      div_next;
    logic             tick;
    logic [3:0]       bit_idx_reg;
    logic [3:0]       bit_idx_next;
    logic [9:0]       frame_reg;   // bits still to be sent after the one on the line
    logic [9:0]       frame_next;
    logic             clk_reg;
    logic             clk_next;
    logic             data_reg;
    logic             data_next;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_next;

    // Host flow control: hold_req freezes IDLE/GAP, abort_req kills a frame
    // that has not yet clocked its stop bit.
    logic hold_req;
    logic abort_req;

`ifdef PS2_TX_INHIBIT_EN
    assign hold_req  = ps2_inhibit;
    assign abort_req = ps2_inhibit & ~((bit_idx_reg == LAST_BIT) & ~clk_reg);
`else
    assign hold_req  = 1'b0;
    assign abort_req = 1'b0;
`endif

    assign fifo_empty = (count_reg == '0);
    assign kbd_full   = (count_reg == FULL_COUNT);
    assign fifo_wr    = kbd_stb & ~kbd_full;
    assign head_byte  = mem[rd_ptr_reg];
    assign tick       = (div_reg == PS2DIV);

    assign overflow = ovf_reg;
    assign busy     = ~fifo_empty | (state_reg != ST_IDLE);
    assign ps2_clk  = clk_reg;
    assign ps2_data = data_reg;

    // FIFO data array: plain RAM without reset, written on accepted strobes.
    always_ff @(posedge clk_p) begin
        if (fifo_wr) begin
            mem[wr_ptr_reg] <= kbd_data;
        end
    end

    // Occupancy: a write and a pop in the same cycle cancel out.
    always_comb begin
        count_next = count_reg;
        case ({fifo_wr, fifo_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointers, occupancy and the dropped-write pulse.
    always_ff @(posedge clk_p or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            ovf_reg   <= kbd_stb & kbd_full;
        end
    end

    // Frame FSM next-state: divider, bit sequencing, line levels and pop.
    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_idx_next = bit_idx_reg;
        frame_next   = frame_reg;
        clk_next     = clk_reg;
        data_next    = data_reg;
        gap_next     = gap_reg;
        fifo_pop     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Lines idle high; divider parked at 0 so SEND starts a fresh tick.
                clk_next  = 1'b1;
                data_next = 1'b1;
                div_next  = '0;
                if (!fifo_empty && !hold_req) begin
                    state_next   = ST_SEND;
                    bit_idx_next = 4'd0;
                    // Latch the head byte now so later writes cannot disturb it.
                    frame_next   = {1'b1, ~^head_byte, head_byte};
                    data_next    = 1'b0;
                end
            end

            ST_SEND: begin
                div_next = tick ? 14'd0 : div_reg + 14'd1;
                if (abort_req) begin
                    state_next = ST_GAP;
                    clk_next   = 1'b1;
                    data_next  = 1'b1;
                    div_next   = '0;
                    gap_next   = '0;
                end else if (tick) begin
                    if (clk_reg) begin
                        // Falling edge: receiver samples the bit on the line.
                        clk_next = 1'b0;
                    end else begin
                        // Rising edge: the only point where data may change.
                        clk_next = 1'b1;
                        if (bit_idx_reg == LAST_BIT) begin
                            fifo_pop   = 1'b1;
                            data_next  = 1'b1;
                            state_next = ST_GAP;
                            gap_next   = '0;
                        end else begin
                            bit_idx_next = bit_idx_reg + 4'd1;
                            data_next    = frame_reg[0];
                            frame_next   = {1'b1, frame_reg[9:1]};
                        end
                    end
                end
            end

            ST_GAP: begin
                clk_next  = 1'b1;
                data_next = 1'b1;
                if (!hold_req) begin
                    div_next = tick ? 14'd0 : div_reg + 14'd1;
                    if (tick) begin
                        if (gap_reg == GAP_LAST) begin
                            state_next = ST_IDLE;
                            gap_next   = '0;
                        end else begin
                            gap_next = gap_reg + GAP_ONE;
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                clk_next   = 1'b1;
                data_next  = 1'b1;
                div_next   = '0;
                gap_next   = '0;
            end
        endcase
    end

    // Frame FSM registers; reset leaves both lines released (high).
    always_ff @(posedge clk_p or negedge nreset) begin
        if (!nreset) begin
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            bit_idx_reg <= '0;
            frame_reg   <= '1;
            clk_reg     <= 1'b1;
            data_reg    <= 1'b1;
            gap_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_idx_reg <= bit_idx_next;
            frame_reg   <= frame_next;
            clk_reg     <= clk_next;
            data_reg    <= data_next;
            gap_reg     <= gap_next;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx - scoreboard bench for ps2_kbd_tx (PS2DIV=3, FIFO_AW=2, GAP_TICKS=4).
// Stimulus pushes hand-computed 11-bit frames ({stop, parity, data, start},
// bit 0 sent first); a monitor collects bits on ps2_clk falls and pops/compares.
`timescale 1ns/1ps
module tb_ps2_kbd_tx;

    localparam logic [13:0] PS2DIV    = 14'd3;
    localparam int          FIFO_AW   = 2;
    localparam int          GAP_TICKS = 4;

    logic       clk_p    = 1'b0;
    logic       nreset   = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_stb  = 1'b0;
    logic       kbd_full;
    logic       overflow;
    logic       busy;
    logic       ps2_clk;
    logic       ps2_data;
`ifdef PS2_TX_INHIBIT_EN
    logic       ps2_inhibit = 1'b0;
`endif

    ps2_kbd_tx #(
        .PS2DIV    (PS2DIV),
        .FIFO_AW   (FIFO_AW),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk_p    (clk_p),
        .nreset   (nreset),
        .kbd_data (kbd_data),
        .kbd_stb  (kbd_stb),
        .kbd_full (kbd_full),
        .overflow (overflow),
        .busy     (busy),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
`ifdef PS2_TX_INHIBIT_EN
        ,
        .ps2_inhibit (ps2_inhibit)
`endif
    );

    always #5 clk_p = ~clk_p;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_p) cyc <= cyc + 1;

    // Scoreboard and monitor state
    logic [10:0] exp_q[$];
    int          fall_cyc_q[$];
    int          frames_done = 0;
    int          falls       = 0;
    int          mon_bits    = 0;
    logic [10:0] mon_shift   = '0;
    logic        mon_flush   = 1'b0;
    logic        prev_clk    = 1'b1;
    logic        low_data    = 1'b1;
    logic        low_stable  = 1'b1;
    int          idle_bad    = 0;

    // Monitor: sample away from the active edge, rebuild frames, compare.
    always @(negedge clk_p) begin
        logic [10:0] exp_frame;
        if (!nreset || mon_flush) begin
            mon_bits   = 0;
            low_stable = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk) begin
                falls++;
                if (mon_bits == 0) fall_cyc_q.push_back(cyc);
                mon_shift  = {ps2_data, mon_shift[10:1]};
                mon_bits++;
                low_data   = ps2_data;
                low_stable = 1'b1;
                if (mon_bits == 11) begin
                    mon_bits = 0;
                    frames_done++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame: got %03h but no frame was expected", mon_shift);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        if (mon_shift !== exp_frame) begin
                            errors++;
                            $display("FAIL frame: got %03h expected %03h", mon_shift, exp_frame);
                        end else begin
                            $display("frame ok: %03h (data %02h)", mon_shift, mon_shift[8:1]);
                        end
                    end
                end
            end else if (!prev_clk && !ps2_clk) begin
                if (ps2_data !== low_data) low_stable = 1'b0;
            end else if (!prev_clk && ps2_clk) begin
                checks++;
                if (!low_stable) begin
                    errors++;
                    $display("FAIL data_stable: ps2_data changed while ps2_clk low (cycle %0d)", cyc);
                end
            end
        end
        if (!busy && !(ps2_clk && ps2_data)) idle_bad++;
        prev_clk = ps2_clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check ok: %s = %0d", name, act);
        end
    endtask

    // One write strobe; called on a falling edge, returns on the next one.
    task automatic put(input logic [7:0] d, input logic [10:0] frame, input bit accepted);
        kbd_data = d;
        kbd_stb  = 1'b1;
        if (accepted) exp_q.push_back(frame);
        @(negedge clk_p);
        kbd_stb  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk_p);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still high after %0d cycles, required low", name, budget);
        end
    endtask

    task automatic wait_bits(input string name, input int nbits, input int budget);
        int n = 0;
        while (mon_bits != nbits && n < budget) begin
            @(negedge clk_p);
            n++;
        end
        if (mon_bits != nbits) begin
            checks++;
            errors++;
            $display("FAIL %s: saw %0d bits after %0d cycles, required %0d", name, mon_bits, budget, nbits);
        end
    endtask

    initial begin
        int base;
        int n;
        int f0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk_p);
        chk("rst_ps2_clk", int'(ps2_clk), 1);
        chk("rst_ps2_data", int'(ps2_data), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_kbd_full", int'(kbd_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk_p);

        // ---------------- 1: single byte 0x1C and start latency ----------------
        base = frames_done;
        put(8'h1C, 11'h438, 1'b1);
        chk("t1_busy_after_write", int'(busy), 1);
        chk("t1_data_idle_cycle1", int'(ps2_data), 1);
        @(negedge clk_p);
        chk("t1_start_bit_on_send", int'(ps2_data), 0);
        chk("t1_clk_high_on_send", int'(ps2_clk), 1);
        n = 0;
        while (ps2_clk && n < 20) begin
            @(negedge clk_p);
            n++;
        end
        chk("t1_first_fall_latency", n, 4);
        wait_idle("t1_idle", 400);
        chk("t1_frames", frames_done - base, 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // ---------------- 2: 0x00 then 0xFF back-to-back ----------------
        base = frames_done;
        fall_cyc_q.delete();
        put(8'h00, 11'h600, 1'b1);
        put(8'hFF, 11'h7FE, 1'b1);
        wait_idle("t2_idle", 600);
        chk("t2_frames", frames_done - base, 2);
        chk("t2_queue_empty", exp_q.size(), 0);
        if (fall_cyc_q.size() == 2) begin
            chk("t2_frame_spacing", fall_cyc_q[1] - fall_cyc_q[0], (22 + GAP_TICKS) * 4 + 1);
        end else begin
            chk("t2_frame_starts", fall_cyc_q.size(), 2);
        end
        @(negedge clk_p);
        chk("t2_busy_low", int'(busy), 0);

        // ---------------- 3: overflow on fifth write ----------------
        base = frames_done;
        put(8'h12, 11'h624, 1'b1);
        put(8'h34, 11'h468, 1'b1);
        put(8'h56, 11'h6AC, 1'b1);
        chk("t3_not_full_at_3", int'(kbd_full), 0);
        put(8'h78, 11'h6F0, 1'b1);
        chk("t3_full_at_4", int'(kbd_full), 1);
        chk("t3_no_overflow_yet", int'(overflow), 0);
        put(8'h9A, 11'h000, 1'b0);
        chk("t3_overflow_pulse", int'(overflow), 1);
        @(negedge clk_p);
        chk("t3_overflow_single", int'(overflow), 0);
        wait_idle("t3_idle", 1200);
        chk("t3_frames", frames_done - base, 4);
        chk("t3_queue_empty", exp_q.size(), 0);

        // ---------------- 5: reset mid-frame ----------------
        put(8'h1C, 11'h438, 1'b1);
        wait_bits("t5_reach_bit5", 6, 200);
        #2;
        nreset = 1'b0;
        #1;
        chk("t5_rst_ps2_clk", int'(ps2_clk), 1);
        chk("t5_rst_ps2_data", int'(ps2_data), 1);
        chk("t5_rst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_p);
        nreset = 1'b1;
        f0 = falls;
        repeat (200) @(negedge clk_p);
        chk("t5_no_edges_after_release", falls - f0, 0);
        chk("t5_busy_after_release", int'(busy), 0);

`ifdef PS2_TX_INHIBIT_EN
        // ---------------- 6: inhibit during bit 4 of 0x5A ----------------
        base = frames_done;
        put(8'h5A, 11'h6B4, 1'b1);
        wait_bits("t6_reach_bit4", 5, 200);
        ps2_inhibit = 1'b1;
        mon_flush   = 1'b1;
        @(negedge clk_p);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_p);
            if (!(ps2_clk && ps2_data)) n++;
        end
        chk("t6_lines_high_inhibit", n, 0);
        chk("t6_busy_while_inhibit", int'(busy), 1);
        ps2_inhibit = 1'b0;
        mon_flush   = 1'b0;
        wait_idle("t6_idle", 400);
        chk("t6_frames", frames_done - base, 1);
        chk("t6_queue_empty", exp_q.size(), 0);
`endif

        // ---------------- 4: line discipline while idle ----------------
        chk("t4_idle_lines_high", idle_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
